// File: rtl/neopixel_frame_sequencer_pkg.sv
// Shared encodings and helpers for the NeoPixel frame sequencer.
// The loader and display FSMs use plain localparam state codes.
package neopixel_frame_sequencer_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  localparam logic [0:0] L_HUNT = 1'b0;
  localparam logic [0:0] L_DATA = 1'b1;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  localparam logic [1:0] COMP_R = 2'd0;
  localparam logic [1:0] COMP_G = 2'd1;
  localparam logic [1:0] COMP_B = 2'd2;

  // Counter width for a count of v, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/neopixel_frame_sequencer_loader.sv
// Frame loader: hunts for the sync byte, then writes R,G,B bytes into the back buffer.
// A frame is only reported complete after its final byte; aborted frames are never committed.
module neopixel_frame_loader
  import neopixel_frame_sequencer_pkg::*;
#(
  parameter int          N_PIXELS   = 10,
  parameter logic [7:0]  HDR_BYTE   = HDR_BYTE_DEFAULT,
  parameter int          RX_TIMEOUT = 100000,
  parameter int          PIX_W      = clog2_min1(N_PIXELS)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_rx_valid,
  input  logic             i_pending,
  output logic             o_wr_en,
  output logic [PIX_W-1:0] o_wr_addr,
  output logic [1:0]       o_wr_comp,
  output logic [7:0]       o_wr_data,
  output logic             o_frame_complete,
  output logic             o_err
);

  localparam int               GAP_W    = clog2_min1(RX_TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_TIMEOUT - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIXELS - 1);

  logic [0:0]       r_state;
  logic [PIX_W-1:0] r_pix;
  logic [1:0]       r_comp;
  logic [GAP_W-1:0] r_gap;

  logic w_hdr;
  logic w_timeout;

  assign w_hdr     = i_rx_valid && (i_rx_byte == HDR_BYTE);
  assign w_timeout = (r_state == L_DATA) && !i_rx_valid && (r_gap == GAP_LAST);

  assign o_wr_en          = (r_state == L_DATA) && i_rx_valid;
  assign o_wr_addr        = r_pix;
  assign o_wr_comp        = r_comp;
  assign o_wr_data        = i_rx_byte;
  assign o_frame_complete = o_wr_en && (r_pix == LAST_PIX) && (r_comp == COMP_B);
  // A header arriving while the previous frame still awaits its swap is an overrun.
  assign o_err            = ((r_state == L_HUNT) && w_hdr && i_pending) || w_timeout;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= L_HUNT;
      r_pix   <= '0;
      r_comp  <= COMP_R;
      r_gap   <= '0;
    end else begin
      case (r_state)
        L_HUNT: begin
          r_gap <= '0;
          if (w_hdr && !i_pending) begin
            r_state <= L_DATA;
            r_pix   <= '0;
            r_comp  <= COMP_R;
          end
        end
        L_DATA: begin
          if (i_rx_valid) begin
            r_gap <= '0;
            if (r_comp == COMP_B) begin
              r_comp <= COMP_R;
              if (r_pix == LAST_PIX) r_state <= L_HUNT;
              else                   r_pix   <= r_pix + 1'b1;
            end else begin
              r_comp <= r_comp + 1'b1;
            end
          end else if (w_timeout) begin
            r_state <= L_HUNT;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= L_HUNT;
      endcase
    end
  end

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Double-buffered LED frame store with a display FSM feeding writepixel over valid/busy.
// Completed frames swap in only between frames, so a displayed frame is never torn.
module neopixel_frame_sequencer
  import neopixel_frame_sequencer_pkg::*;
#(
  parameter int          N_PIXELS       = 10,
  parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT,
  parameter int          LATCH_CYCLES   = 4000,
  parameter int          REFRESH_CYCLES = 2097152,
  parameter int          RX_TIMEOUT     = 100000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  input  logic       i_busy,
  output logic       o_valid,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue,
  output logic       o_frame_done,
  output logic       o_load_err
);

  localparam int               PIX_W    = clog2_min1(N_PIXELS);
  localparam int               TMR_W    = clog2_min1(REFRESH_CYCLES);
  localparam int               LAT_W    = clog2_min1(LATCH_CYCLES);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIXELS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);

  logic [7:0]       r_bank [2][N_PIXELS][3];
  logic             r_sel;
  logic             r_pending;
  logic [2:0]       r_state;
  logic [PIX_W-1:0] r_pix;
  logic [TMR_W-1:0] r_timer;
  logic [LAT_W-1:0] r_latch;

  logic             w_wr_en;
  logic [PIX_W-1:0] w_wr_addr;
  logic [1:0]       w_wr_comp;
  logic [7:0]       w_wr_data;
  logic             w_frame_complete;
  logic             w_err;
  logic             w_back_sel;

  assign w_back_sel = ~r_sel;

  neopixel_frame_loader #(
    .N_PIXELS   (N_PIXELS),
    .HDR_BYTE   (HDR_BYTE),
    .RX_TIMEOUT (RX_TIMEOUT),
    .PIX_W      (PIX_W)
  ) u_loader (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .i_rx_byte        (i_rx_byte),
    .i_rx_valid       (i_rx_valid),
    .i_pending        (r_pending),
    .o_wr_en          (w_wr_en),
    .o_wr_addr        (w_wr_addr),
    .o_wr_comp        (w_wr_comp),
    .o_wr_data        (w_wr_data),
    .o_frame_complete (w_frame_complete),
    .o_err            (w_err)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < N_PIXELS; p++)
          for (int c = 0; c < 3; c++)
            r_bank[b][p][c] <= '0;
    end else if (w_wr_en) begin
      r_bank[w_back_sel][w_wr_addr][w_wr_comp] <= w_wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_pending    <= 1'b0;
      r_pix        <= '0;
      r_timer      <= '0;
      r_latch      <= '0;
      o_valid      <= 1'b0;
      o_red        <= '0;
      o_green      <= '0;
      o_blue       <= '0;
      o_frame_done <= 1'b0;
      o_load_err   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_load_err   <= w_err;
      if (r_timer != TMR_LAST) r_timer <= r_timer + 1'b1;
      if (w_frame_complete)    r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          // A pending frame preempts the refresh timer and starts immediately.
          if (r_pending || (r_timer == TMR_LAST)) begin
            if (r_pending) begin
              r_sel     <= ~r_sel;
              r_pending <= 1'b0;
            end
            r_pix   <= '0;
            r_timer <= '0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i_busy) begin
            o_valid <= 1'b1;
            o_red   <= r_bank[r_sel][r_pix][COMP_R];
            o_green <= r_bank[r_sel][r_pix][COMP_G];
            o_blue  <= r_bank[r_sel][r_pix][COMP_B];
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (i_busy) begin
            o_valid <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!i_busy) begin
            if (r_pix == LAST_PIX) begin
              r_latch <= '0;
              r_state <= S_LATCH;
            end else begin
              r_pix   <= r_pix + 1'b1;
              r_state <= S_ISSUE;
            end
          end
        end
        S_LATCH: begin
          if (r_latch == LAT_LAST) begin
            o_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_latch <= r_latch + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Directed bench for neopixel_frame_sequencer with a simple writepixel model.
// Each scenario task drives stimulus and compares against hand-computed values.
module tb_neopixel_frame_sequencer;

  localparam int N_PIX   = 3;
  localparam int REFRESH = 1000;
  localparam int LATCH   = 20;
  localparam int RXTO    = 200;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] i_rx_byte = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic       i_busy = 1'b0;
  logic       o_valid;
  logic [7:0] o_red;
  logic [7:0] o_green;
  logic [7:0] o_blue;
  logic       o_frame_done;
  logic       o_load_err;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int err_cnt = 0;
  int proto_err = 0;
  int busy_cnt = 0;
  logic [23:0] pix_q[$];
  int          pix_cyc[$];
  logic        prev_valid = 1'b0;
  logic        prev_overlap = 1'b0;
  logic        prev_hold = 1'b0;
  logic [23:0] prev_rgb = '0;

  neopixel_frame_sequencer #(
    .N_PIXELS       (N_PIX),
    .HDR_BYTE       (8'hA5),
    .LATCH_CYCLES   (LATCH),
    .REFRESH_CYCLES (REFRESH),
    .RX_TIMEOUT     (RXTO)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .i_rx_byte    (i_rx_byte),
    .i_rx_valid   (i_rx_valid),
    .i_busy       (i_busy),
    .o_valid      (o_valid),
    .o_red        (o_red),
    .o_green      (o_green),
    .o_blue       (o_blue),
    .o_frame_done (o_frame_done),
    .o_load_err   (o_load_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  // Writepixel model: busy rises just after valid is seen and stays up for 30 cycles.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (!RST_N) begin
        busy_cnt = 0;
        i_busy = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) i_busy = 1'b0;
      end else if (o_valid && !i_busy) begin
        i_busy = 1'b1;
        busy_cnt = 30;
      end
    end
  end

  // Monitor: records pixels, pulses and handshake violations.
  always @(negedge CLK) begin
    logic [23:0] rgb;
    logic hold;
    rgb = {o_red, o_green, o_blue};
    hold = o_valid || i_busy;
    if (o_valid && !prev_valid) begin
      pix_q.push_back(rgb);
      pix_cyc.push_back(cycle);
    end
    if (o_valid && i_busy && prev_overlap) proto_err++;
    if (hold && prev_hold && (rgb != prev_rgb)) proto_err++;
    if (o_frame_done) begin
      done_cnt++;
      done_cyc = cycle;
    end
    if (o_load_err) err_cnt++;
    prev_overlap = o_valid && i_busy;
    prev_valid = o_valid;
    prev_hold = hold;
    prev_rgb = rgb;
  end

  task automatic wait_pixels(input int n, input int budget, output bit ok);
    int k = 0;
    while (pix_q.size() < n && k < budget) begin
      @(negedge CLK);
      k++;
    end
    ok = (pix_q.size() >= n);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge CLK);
      k++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    i_rx_byte = b;
    i_rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] data);
    send_byte(8'hA5);
    for (int i = 0; i < 9; i++) send_byte(data[71-8*i -: 8]);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (5) @(negedge CLK);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
    checks++;
    if ({o_red, o_green, o_blue} !== 24'h0) begin errors++; $display("[TB] FAIL reset_rgb got %h want 000000", {o_red, o_green, o_blue}); end
    checks++;
    if (o_frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", o_frame_done); end
    checks++;
    if (o_load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", o_load_err); end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_idle_refresh();
    int base;
    int d0;
    bit ok;
    base = pix_q.size();
    d0 = done_cnt;
    wait_pixels(base + 4, 2500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL refresh_timeout got %0d pixels want %0d", pix_q.size() - base, 4); return; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix_q[base+i] !== 24'h0) begin errors++; $display("[TB] FAIL refresh_pix%0d got %h want 000000", i, pix_q[base+i]); end
    end
    checks++;
    if (pix_cyc[base+3] - pix_cyc[base] != REFRESH) begin
      errors++; $display("[TB] FAIL refresh_period got %0d want %0d", pix_cyc[base+3] - pix_cyc[base], REFRESH);
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL refresh_done_count got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_load_frame();
    int base;
    bit ok;
    logic [23:0] exp [3];
    exp = '{24'h102030, 24'h405060, 24'h708090};
    wait_done(done_cnt + 1, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL load_sync got done=%0d want more", done_cnt); return; end
    base = pix_q.size();
    send_frame(72'h10_20_30_40_50_60_70_80_90);
    wait_pixels(base + 6, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL load_timeout got %0d pixels want 6", pix_q.size() - base); return; end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (pix_q[base+i] !== exp[i%3]) begin errors++; $display("[TB] FAIL load_pix%0d got %h want %h", i, pix_q[base+i], exp[i%3]); end
    end
    checks++;
    if (pix_cyc[base] - done_cyc >= 100) begin errors++; $display("[TB] FAIL load_prompt_start got %0d cycles want <100", pix_cyc[base] - done_cyc); end
    checks++;
    if (proto_err != 0) begin errors++; $display("[TB] FAIL handshake got %0d violations want 0", proto_err); end
  endtask

  task automatic test_mid_frame_swap();
    int base;
    bit ok;
    logic [23:0] exp [4];
    exp = '{24'h708090, 24'h010203, 24'h040506, 24'h070809};
    wait_done(done_cnt + 1, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL swap_sync got done=%0d want more", done_cnt); return; end
    base = pix_q.size();
    wait_pixels(base + 2, 1500, ok);
    send_frame(72'h01_02_03_04_05_06_07_08_09);
    wait_pixels(base + 6, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL swap_timeout got %0d pixels want 6", pix_q.size() - base); return; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pix_q[base+2+i] !== exp[i]) begin errors++; $display("[TB] FAIL swap_pix%0d got %h want %h", i, pix_q[base+2+i], exp[i]); end
    end
    checks++;
    if (pix_cyc[base+3] - done_cyc != 2) begin errors++; $display("[TB] FAIL swap_start_gap got %0d want 2", pix_cyc[base+3] - done_cyc); end
  endtask

  task automatic test_rx_timeout();
    int base;
    int e0;
    bit ok;
    logic [23:0] old_exp [3];
    logic [23:0] new_exp [3];
    old_exp = '{24'h010203, 24'h040506, 24'h070809};
    new_exp = '{24'h21A523, 24'h242526, 24'h272829};
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    checks++;
    if (err_cnt != e0) begin errors++; $display("[TB] FAIL timeout_early got %0d errs want 0", err_cnt - e0); end
    repeat (RXTO + 20) @(negedge CLK);
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("[TB] FAIL timeout_err got %0d pulses want 1", err_cnt - e0); end
    wait_done(done_cnt + 1, 1500, ok);
    base = pix_q.size();
    wait_pixels(base + 3, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL timeout_frame got %0d pixels want 3", pix_q.size() - base); return; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix_q[base+i] !== old_exp[i]) begin errors++; $display("[TB] FAIL timeout_keep%0d got %h want %h", i, pix_q[base+i], old_exp[i]); end
    end
    wait_done(done_cnt + 1, 1500, ok);
    base = pix_q.size();
    send_frame(72'h21_A5_23_24_25_26_27_28_29);
    wait_pixels(base + 3, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL reload_frame got %0d pixels want 3", pix_q.size() - base); return; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix_q[base+i] !== new_exp[i]) begin errors++; $display("[TB] FAIL reload_pix%0d got %h want %h", i, pix_q[base+i], new_exp[i]); end
    end
  endtask

  task automatic test_overrun();
    int base;
    int e0;
    bit ok;
    logic [23:0] exp [3];
    exp = '{24'hD1D2D3, 24'hD4D5D6, 24'hD7D8D9};
    wait_done(done_cnt + 1, 1500, ok);
    base = pix_q.size();
    wait_pixels(base + 1, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL overrun_sync got %0d pixels want 1", pix_q.size() - base); return; end
    e0 = err_cnt;
    send_frame(72'hD1_D2_D3_D4_D5_D6_D7_D8_D9);
    send_byte(8'hA5);
    send_byte(8'hE1);
    repeat (3) @(negedge CLK);
    checks++;
    if (err_cnt - e0 != 1) begin errors++; $display("[TB] FAIL overrun_err got %0d pulses want 1", err_cnt - e0); end
    wait_done(done_cnt + 1, 1500, ok);
    base = pix_q.size();
    wait_pixels(base + 3, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL overrun_frame got %0d pixels want 3", pix_q.size() - base); return; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix_q[base+i] !== exp[i]) begin errors++; $display("[TB] FAIL overrun_pix%0d got %h want %h", i, pix_q[base+i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    int k = 0;
    bit ok;
    while (!o_valid && k < 1500) begin
      @(negedge CLK);
      k++;
    end
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_sync got valid=%b want 1", o_valid); return; end
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_valid got %b want 0", o_valid); end
    checks++;
    if ({o_red, o_green, o_blue} !== 24'h0) begin errors++; $display("[TB] FAIL midreset_rgb got %h want 000000", {o_red, o_green, o_blue}); end
    #2;
    RST_N = 1'b1;
    base = pix_q.size();
    wait_pixels(base + 3, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL midreset_frame got %0d pixels want 3", pix_q.size() - base); return; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pix_q[base+i] !== 24'h0) begin errors++; $display("[TB] FAIL midreset_pix%0d got %h want 000000", i, pix_q[base+i]); end
    end
  endtask

  initial begin
    $display("[TB] starting neopixel_frame_sequencer bench");
    test_reset();
    test_idle_refresh();
    test_load_frame();
    test_mid_frame_swap();
    test_rx_timeout();
    test_overrun();
    test_reset_mid_frame();
    checks++;
    if (proto_err != 0) begin errors++; $display("[TB] FAIL handshake_final got %0d violations want 0", proto_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
